// File: rtl/serial_rshifter.sv
`default_nettype none
// ============================================================================
// Module  : serial_rshifter
// Brief   : Iterative one-bit-per-clock right shifter/rotator with start/ready/
//           done_tick handshake for the barrel shifter datapath.
// Revision: 1.0
// ============================================================================
module serial_rshifter #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] din,
    input  logic [W-1:0] amt,
    input  logic         rot,
    output logic         ready,
    output logic         done_tick,
    output logic [N-1:0] dout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [W-1:0] c_zero = '0;
    localparam logic [W-1:0] c_one  = W'(1);

    state_t       state_q, state_d;
    logic [N-1:0] data_q,  data_d;
    logic [W-1:0] cnt_q,   cnt_d;
    logic         rot_q,   rot_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            rot_q   <= rot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        rot_d   = rot_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d  = din;
                    cnt_d   = amt;
                    rot_d   = rot;
                    state_d = (amt == c_zero) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                // rot_q selects whether the bit leaving the LSB re-enters at the MSB
                data_d = {rot_q & data_q[0], data_q[N-1:1]};
                cnt_d  = cnt_q - c_one;
                if (cnt_q == c_one) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready     = (state_q == S_IDLE);
    assign done_tick = (state_q == S_DONE);
    assign dout      = data_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_rshifter.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_rshifter
// Brief   : Self-checking bench for serial_rshifter against an arithmetic model.
// Revision: 1.0
// ============================================================================
module tb_serial_rshifter;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] din;
    logic [W-1:0] amt;
    logic         rot;
    logic         ready;
    logic         done_tick;
    logic [N-1:0] dout;

    int n_vec = 0;
    int n_err = 0;

    serial_rshifter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .din       (din),
        .amt       (amt),
        .rot       (rot),
        .ready     (ready),
        .done_tick (done_tick),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int a, input logic r);
        logic [2*N-1:0] wide;
        logic [N-1:0]   res;
        if (r) begin
            wide = {d, d} >> a;
            res  = wide[N-1:0];
        end else begin
            res = d >> a;
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation from IDLE and wait (bounded) for done_tick.
    task automatic run_op(input logic [N-1:0] d, input logic [W-1:0] a, input logic r,
                          output logic [N-1:0] res, output int lat);
        start = 1'b1;
        din   = d;
        amt   = a;
        rot   = r;
        tick();
        start = 1'b0;
        din   = N'($urandom);
        amt   = W'($urandom_range(N - 1, 0));
        rot   = 1'($urandom_range(1, 0));
        lat   = 1;
        while (done_tick !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        res = dout;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        din   = '0;
        amt   = '0;
        rot   = 1'b0;
        #12;
        n_vec++;
        if (dout !== 8'h00 || ready !== 1'b1 || done_tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset: dout=%h ready=%b done=%b, want dout=00 ready=1 done=0",
                     dout, ready, done_tick);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_logical();
        logic [N-1:0] exp_v;
        int           lat;
        exp_v = ref_shift(8'hB4, 2, 1'b0);
        start = 1'b1; din = 8'hB4; amt = 3'd2; rot = 1'b0;
        tick();
        start = 1'b0; din = 8'hFF; amt = 3'd7; rot = 1'b1;
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL logical_ready_drop: ready=%b want 0", ready);
        end
        lat = 1;
        while (done_tick !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_vec++;
        if (lat !== 3 || dout !== exp_v) begin
            n_err++;
            $display("FAIL logical_b4: lat=%0d dout=%h, want lat=3 dout=%h", lat, dout, exp_v);
        end
        tick();
        n_vec++;
        if (ready !== 1'b1 || done_tick !== 1'b0) begin
            n_err++;
            $display("FAIL logical_ready_back: ready=%b done=%b, want 1/0", ready, done_tick);
        end
    endtask

    task automatic test_rotate();
        logic [N-1:0] res;
        int           lat;
        int           amts[2] = '{1, 7};
        foreach (amts[i]) begin
            run_op(8'h81, W'(amts[i]), 1'b1, res, lat);
            n_vec++;
            if (lat !== amts[i] + 1 || res !== ref_shift(8'h81, amts[i], 1'b1)) begin
                n_err++;
                $display("FAIL rotate_amt%0d: lat=%0d dout=%h, want lat=%0d dout=%h",
                         amts[i], lat, res, amts[i] + 1, ref_shift(8'h81, amts[i], 1'b1));
            end
            tick();
        end
    endtask

    task automatic test_zero_amt();
        logic [N-1:0] res;
        int           lat;
        run_op(8'h5A, 3'd0, 1'b0, res, lat);
        n_vec++;
        if (lat !== 1 || res !== 8'h5A) begin
            n_err++;
            $display("FAIL zero_amt: lat=%0d dout=%h, want lat=1 dout=5a", lat, res);
        end
        tick();
    endtask

    task automatic test_start_held();
        int           cycles;
        int           dt;
        int           lat;
        logic [N-1:0] res;
        start = 1'b1; din = 8'hFF; amt = 3'd7; rot = 1'b0;
        tick();
        din = 8'h00;
        cycles = 1; dt = 0; lat = 0; res = '0;
        while (ready !== 1'b1 && cycles < 40) begin
            if (done_tick === 1'b1) begin
                dt++;
                lat = cycles;
                res = dout;
            end
            tick();
            cycles++;
        end
        n_vec++;
        if (dt !== 1 || lat !== 8 || res !== ref_shift(8'hFF, 7, 1'b0)) begin
            n_err++;
            $display("FAIL start_held: ticks=%0d lat=%0d dout=%h, want ticks=1 lat=8 dout=%h",
                     dt, lat, res, ref_shift(8'hFF, 7, 1'b0));
        end
        // start still high: the second operation is accepted only now
        tick();
        start = 1'b0;
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL start_held_second_accept: ready=%b want 0", ready);
        end
        cycles = 0;
        while (done_tick !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        n_vec++;
        if (done_tick !== 1'b1 || dout !== 8'h00) begin
            n_err++;
            $display("FAIL start_held_second_result: done=%b dout=%h, want 1/00", done_tick, dout);
        end
        tick();
    endtask

    task automatic test_abort();
        int dt;
        start = 1'b1; din = 8'hF0; amt = 3'd5; rot = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if (dout !== 8'h00 || ready !== 1'b1 || done_tick !== 1'b0) begin
            n_err++;
            $display("FAIL abort_async: dout=%h ready=%b done=%b, want 00/1/0",
                     dout, ready, done_tick);
        end
        #1 reset = 1'b0;
        dt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done_tick === 1'b1) dt++;
        end
        n_vec++;
        if (dt !== 0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_no_done: ticks=%0d ready=%b, want 0/1", dt, ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] d;
        logic [W-1:0] a;
        logic         r;
        logic [N-1:0] res;
        int           lat;
        int           ndone;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            d = N'($urandom);
            a = W'($urandom_range(N - 1, 0));
            r = 1'($urandom_range(1, 0));
            run_op(d, a, r, res, lat);
            if (done_tick === 1'b1) ndone++;
            n_vec++;
            if (lat !== int'(a) + 1 || res !== ref_shift(d, int'(a), r)) begin
                n_err++;
                $display("FAIL b2b[%0d] din=%h amt=%0d rot=%b: lat=%0d dout=%h, want lat=%0d dout=%h",
                         i, d, a, r, lat, res, int'(a) + 1, ref_shift(d, int'(a), r));
            end
            tick();
            n_vec++;
            if (ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready[%0d]: ready=%b want 1", i, ready);
            end
        end
        n_vec++;
        if (ndone !== 20) begin
            n_err++;
            $display("FAIL b2b_done_count: got %0d want 20", ndone);
        end
    endtask

    initial begin
        test_reset();
        test_logical();
        test_rotate();
        test_zero_amt();
        test_start_held();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
